// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle unsigned-magnitude multiply/divide engine for the
// Execute stage. Signed ops have their operand signs stripped on accept. The
// HI/LO write-back logic applies sign fix-up and accumulation downstream.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous active-high reset
//   flush   in   abort the in-flight op
//   start   in   request, sampled only while idle
//   op      in   op_t operation select
//   a, b    in   32-bit rs / rt operands
//   busy    out  engine occupied (state != IDLE)
//   done    out  single-cycle result-valid pulse
//   mult_c  out  64-bit product of magnitudes
//   div_c   out  {remainder, quotient} of magnitudes

package muldiv_pkg;
  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_MADD  = 4'd2,
    OP_MADDU = 4'd3,
    OP_MSUB  = 4'd4,
    OP_MSUBU = 4'd5,
    OP_DIV   = 4'd6,
    OP_DIVU  = 4'd7
  } op_t;
endpackage

module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        start,
  input  op_t         op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] mult_c,
  output logic [63:0] div_c
);

  localparam int unsigned CntW  = 6;
  localparam int unsigned DivIt = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_MUL_PP, S_MUL_SUM, S_DIV_ITER, S_DONE
  } state_t;

  state_t          r_state;
  logic [31:0]     r_a, r_b;
  logic [31:0]     r_ll, r_lh, r_hl, r_hh;
  logic [31:0]     r_rem, r_quot;
  logic [CntW-1:0] r_count;
  logic [63:0]     r_mult, r_div;

  logic        w_legal, w_signed, w_is_div;
  logic [31:0] w_abs_a, w_abs_b;
  logic [32:0] w_rem_sh, w_diff;
  logic        w_rem_ge;
  logic [32:0] w_mid;
  logic [63:0] w_prod;

  // Op decode and operand magnitudes; -0x8000_0000 wraps back to itself.
  assign w_legal  = op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU,
                               OP_MSUB, OP_MSUBU, OP_DIV, OP_DIVU};
  assign w_signed = op inside {OP_MULT, OP_MADD, OP_MSUB, OP_DIV};
  assign w_is_div = op inside {OP_DIV, OP_DIVU};
  assign w_abs_a  = (w_signed && a[31]) ? (~a + 32'd1) : a;
  assign w_abs_b  = (w_signed && b[31]) ? (~b + 32'd1) : b;

  // One restoring-division step. The shifted remainder is at most 2*|b|-1,
  // so the difference never reaches bit 32 unless it went negative.
  assign w_rem_sh = {r_rem, r_quot[31]};
  assign w_diff   = w_rem_sh - {1'b0, r_b};
  assign w_rem_ge = ~w_diff[32];

  // Partial-product sum with the 33-bit middle term kept whole.
  assign w_mid  = 33'(r_lh) + 33'(r_hl);
  assign w_prod = {r_hh, 32'd0} + (64'(w_mid) << 16) + 64'(r_ll);

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_ll    <= '0;
      r_lh    <= '0;
      r_hl    <= '0;
      r_hh    <= '0;
      r_rem   <= '0;
      r_quot  <= '0;
      r_count <= '0;
      r_mult  <= '0;
      r_div   <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && w_legal) begin
            r_a <= w_abs_a;
            r_b <= w_abs_b;
            if (w_is_div) begin
              r_rem   <= '0;
              r_quot  <= w_abs_a;
              r_count <= '0;
              r_state <= S_DIV_ITER;
            end else begin
              r_state <= S_MUL_PP;
            end
          end
        end
        S_MUL_PP: begin
          r_ll    <= 32'(r_a[15:0])  * 32'(r_b[15:0]);
          r_lh    <= 32'(r_a[15:0])  * 32'(r_b[31:16]);
          r_hl    <= 32'(r_a[31:16]) * 32'(r_b[15:0]);
          r_hh    <= 32'(r_a[31:16]) * 32'(r_b[31:16]);
          r_state <= S_MUL_SUM;
        end
        S_MUL_SUM: begin
          r_mult  <= w_prod;
          r_state <= S_DONE;
        end
        S_DIV_ITER: begin
          if (r_b == 32'd0) begin
            r_div   <= {r_a, 32'hFFFF_FFFF};
            r_state <= S_DONE;
          end else if (r_count == CntW'(DivIt)) begin
            // All 32 steps taken: dedicated write-back cycle.
            r_div   <= {r_rem, r_quot};
            r_count <= '0;
            r_state <= S_DONE;
          end else begin
            r_rem   <= w_rem_ge ? w_diff[31:0] : w_rem_sh[31:0];
            r_quot  <= {r_quot[30:0], w_rem_ge};
            r_count <= r_count + CntW'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE) && !flush;
  assign mult_c = r_mult;
  assign div_c  = r_div;

endmodule
